// File: rtl/ntt_stage_sequencer.sv
// Stage controller for the 257-point NTT memory subsystem: sequences stage/incr/soft_reset of mem_control.
// Optional abort path (ports abort/aborted) is compiled in when NTT_SEQ_ABORT_EN is defined.
module ntt_stage_sequencer #(
  parameter int STAGE_LEN  = 85,
  parameter int NUM_STAGES = 3,
  parameter int DRAIN_CYC  = 4,
  localparam int CNT_W = $clog2(STAGE_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
`ifdef NTT_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [1:0]       stage,
  output logic             incr,
  output logic             soft_reset,
  output logic [CNT_W-1:0] step_cnt
);

  // state | meaning
  // IDLE  | waiting for start
  // CLR   | one-cycle soft_reset of mem_control at stage entry
  // RUN   | issuing incr strobes, held off by stall
  // DRAIN | butterfly pipeline flush after the last incr
  // DONE  | one-cycle done pulse
  // ABORT | one-cycle soft_reset after an abort
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE, S_ABORT} state_t;

  localparam int DRN_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(STAGE_LEN - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD   = (DRAIN_CYC > 0) ? DRN_W'(DRAIN_CYC - 1) : '0;
  localparam logic [1:0]       LAST_STAGE = 2'(NUM_STAGES - 1);

  state_t           state, state_nxt;
  logic [1:0]       stage_nxt;
  logic [CNT_W-1:0] step_nxt;
  logic [DRN_W-1:0] drn_cnt, drn_nxt;
  logic             stage_end;
  logic             abort_req;

`ifdef NTT_SEQ_ABORT_EN
  assign abort_req = abort;
  assign aborted   = (state == S_ABORT);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      stage    <= '0;
      step_cnt <= '0;
      drn_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      stage    <= stage_nxt;
      step_cnt <= step_nxt;
      drn_cnt  <= drn_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    stage_nxt  = stage;
    step_nxt   = step_cnt;
    drn_nxt    = drn_cnt;
    busy       = 1'b0;
    done       = 1'b0;
    incr       = 1'b0;
    soft_reset = 1'b0;
    stage_end  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLR;
          stage_nxt = '0;
        end
      end
      S_CLR: begin
        busy       = 1'b1;
        soft_reset = 1'b1;
        step_nxt   = '0;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        incr = !stall;
        if (incr) begin
          step_nxt = step_cnt + 1'b1;
          if (step_cnt == LAST_STEP) begin
            if (DRAIN_CYC > 0) begin
              state_nxt = S_DRAIN;
              drn_nxt   = DRN_LOAD;
            end else begin
              stage_end = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drn_cnt == '0) stage_end = 1'b1;
        else               drn_nxt   = drn_cnt - 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        stage_nxt = '0;
        state_nxt = S_IDLE;
      end
      S_ABORT: begin
        soft_reset = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (stage_end) begin
      if (stage == LAST_STAGE) begin
        state_nxt = S_DONE;
      end else begin
        stage_nxt = stage + 1'b1;
        state_nxt = S_CLR;
      end
    end

    // abort wins over any stage-end decision made this cycle
    if (abort_req && busy) begin
      state_nxt = S_ABORT;
      stage_nxt = '0;
      step_nxt  = '0;
      drn_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: offset-based reference model checked every cycle, plus literal timing checks.
module tb_ntt_stage_sequencer;
  localparam int L  = 85;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int P  = 1 + L + D;
  localparam int CW = $clog2(L + 1);

  logic clk = 1'b0;
  logic reset_n, start, stall, abort_in;
  logic busy, done, incr, soft_reset;
  logic [1:0] stage;
  logic [CW-1:0] step_cnt;
  logic aborted;

  logic s_start, s_stall, s_abort;
  logic s_busy, s_done, s_incr, s_soft_reset, s_aborted;
  logic [1:0] s_stage;
  logic [0:0] s_step;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_stage_sequencer #(.STAGE_LEN(L), .NUM_STAGES(N), .DRAIN_CYC(D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
`ifdef NTT_SEQ_ABORT_EN
    .abort(abort_in), .aborted(aborted),
`endif
    .busy(busy), .done(done), .stage(stage), .incr(incr),
    .soft_reset(soft_reset), .step_cnt(step_cnt)
  );

  ntt_stage_sequencer #(.STAGE_LEN(1), .NUM_STAGES(1), .DRAIN_CYC(0)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .stall(s_stall),
`ifdef NTT_SEQ_ABORT_EN
    .abort(s_abort), .aborted(s_aborted),
`endif
    .busy(s_busy), .done(s_done), .stage(s_stage), .incr(s_incr),
    .soft_reset(s_soft_reset), .step_cnt(s_step)
  );

`ifndef NTT_SEQ_ABORT_EN
  assign aborted   = 1'b0;
  assign s_aborted = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transform is N passes of P cycles; offset o within a pass is
  // 0 for the clear cycle, 1..L for increment slots (frozen while stalled), then drain.
  bit m_act, m_done, m_abt;
  int m_k, m_o, m_last;

  always @(posedge clk) begin : model
    int no;
    if (!reset_n) begin
      m_act <= 0; m_done <= 0; m_abt <= 0; m_k <= 0; m_o <= 0; m_last <= 0;
    end else if (m_abt) begin
      m_abt <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_act) begin
      if (start) begin m_act <= 1; m_k <= 0; m_o <= 0; end
    end else if (abort_in) begin
      m_act <= 0; m_abt <= 1; m_last <= 0; m_k <= 0;
    end else if (!(m_o >= 1 && m_o <= L && stall)) begin
      no = m_o + 1;
      if (m_o == L) m_last <= L;
      if (no == P) begin
        if (m_k == N - 1) begin m_act <= 0; m_done <= 1; end
        else begin m_k <= m_k + 1; m_o <= 0; end
      end else begin
        m_o <= no;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_act);
      check("done", done, m_done);
      check("soft_reset", soft_reset, (m_act && m_o == 0) || m_abt);
      check("incr", incr, m_act && m_o >= 1 && m_o <= L && !stall);
      check("stage", stage, (m_act || m_done) ? m_k : 0);
      check("step_cnt", step_cnt, (m_act && m_o >= 1) ? ((m_o <= L) ? m_o - 1 : L) : m_last);
`ifdef NTT_SEQ_ABORT_EN
      check("aborted", aborted, m_abt);
`endif
    end
  end

  // Event log relative to the last accepted start (offset 1 = first cycle after the start edge)
  int sr_q[$];
  int done_q[$];
  int incr_tot;
  int incr_stage[4];
  int max_step;

  always @(negedge clk) begin
    if (chk_en) begin
      if (soft_reset) sr_q.push_back(cyc - t0 + 1);
      if (done) done_q.push_back(cyc - t0 + 1);
      if (incr) begin incr_tot++; incr_stage[stage]++; end
      if (int'(step_cnt) > max_step) max_step = int'(step_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    sr_q.delete(); done_q.delete();
    incr_tot = 0; max_step = 0;
    for (int i = 0; i < 4; i++) incr_stage[i] = 0;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    clear_log();
  endtask

  task automatic check_done_at(input string name, input int exp);
    check({name, "_done_count"}, done_q.size(), 1);
    check({name, "_done_at"}, (done_q.size() > 0) ? done_q[0] : -1, exp);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; abort_in = 1'b0;
    s_start = 1'b0; s_stall = 1'b0; s_abort = 1'b0;
    clear_log();
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_stage", stage, 0);
    check("rst_step", step_cnt, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // A: plain transform
    run_start();
    repeat (290) tick();
    check("A_sr_count", sr_q.size(), 3);
    check("A_sr0", (sr_q.size() > 0) ? sr_q[0] : -1, 1);
    check("A_sr1", (sr_q.size() > 1) ? sr_q[1] : -1, 91);
    check("A_sr2", (sr_q.size() > 2) ? sr_q[2] : -1, 181);
    check_done_at("A", 271);
    check("A_incr_total", incr_tot, 255);
    for (int k = 0; k < N; k++) check("A_stage_incr", incr_stage[k], 85);

    // B: ten stall cycles in the middle of stage 1
    run_start();
    repeat (130) tick();
    stall = 1'b1;
    repeat (10) tick();
    stall = 1'b0;
    repeat (170) tick();
    check_done_at("B", 281);
    check("B_incr_total", incr_tot, 255);

    // C: stall held on the final step of stage 0
    run_start();
    repeat (85) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (200) tick();
    check_done_at("C", 274);
    check("C_max_step", max_step, 85);
    check("C_incr_total", incr_tot, 255);

    // D: start re-pulsed during RUN and during DONE, then a clean rerun
    run_start();
    repeat (49) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (220) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (30) tick();
    check_done_at("D", 271);
    check("D_sr_count", sr_q.size(), 3);
    run_start();
    repeat (290) tick();
    check_done_at("E", 271);

    // F: reset at step 40 of stage 1
    run_start();
    repeat (130) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("F_busy", busy, 0);
    check("F_stage", stage, 0);
    check("F_incr", incr, 0);
    check("F_soft_reset", soft_reset, 0);
    tick();
    repeat (300) tick();
    check("F_no_done", done_q.size(), 0);
    run_start();
    repeat (290) tick();
    check_done_at("F2", 271);
    check("F2_incr_total", incr_tot, 255);

    // Random stall and start traffic; every finished transform must account for 255 incr
    for (int r = 0; r < 3; r++) begin
      run_start();
      for (int c = 0; c < 400; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 49) == 0);
        tick();
      end
      stall = 1'b0; start = 1'b0;
      repeat (400) tick();
      check("R_done_seen", done_q.size() > 0, 1);
      check("R_incr_total", incr_tot, 255 * done_q.size());
      check("R_max_step", max_step <= L, 1);
    end

    // Minimal configuration: one stage, one step, no drain
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int off = 1; off <= 5; off++) begin
      @(negedge clk);
      check("S_soft_reset", s_soft_reset, off == 1);
      check("S_incr", s_incr, off == 2);
      check("S_done", s_done, off == 3);
      tick();
    end

`ifdef NTT_SEQ_ABORT_EN
    // Abort during the drain of stage 0
    run_start();
    repeat (87) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    @(negedge clk);
    check("X_aborted", aborted, 1);
    check("X_soft_reset", soft_reset, 1);
    check("X_busy", busy, 0);
    tick();
    repeat (300) tick();
    check("X_no_done", done_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
